// File: rtl/replica_pkg.sv
// Shared replica constants: slot geometry, splitmix64 constants and the
// seed sequencer state encoding.
package replica_pkg;

  localparam int base_num = 8;
  localparam int base_log = 3;

  localparam logic [63:0] SM_GAMMA = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] SM_M1    = 64'hBF58476D1CE4E5B9;
  localparam logic [63:0] SM_M2    = 64'h94D049BB133111EB;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    D_ADDR,
    D_READ,
    D_CAP,
    D_OUT
  } seq_state_t;

  // An all-zero state would lock the downstream xorshift generators at zero.
  function automatic logic [63:0] nonzero_seed(input logic [63:0] z);
    return (z == 64'd0) ? 64'd1 : z;
  endfunction

endpackage

// File: rtl/splitmix_mix.sv
// Purely combinational splitmix64 finalizer (xor-shift / multiply chain).
module splitmix_mix
  import replica_pkg::*;
(
  input  logic [63:0] z_in,
  output logic [63:0] z_out
);

  logic [63:0] s1;
  logic [63:0] m1;
  logic [63:0] s2;
  logic [63:0] m2;

  assign s1    = z_in ^ (z_in >> 30);
  assign m1    = s1 * SM_M1;
  assign s2    = m1 ^ (m1 >> 27);
  assign m2    = s2 * SM_M2;
  assign z_out = m2 ^ (m2 >> 31);

endmodule

// File: rtl/seed_sequencer.sv
// Fills every replica seed slot from one master seed via splitmix64 and
// dumps the slots back through the store's registered read path.
module seed_sequencer
  import replica_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         master_seed,
  input  logic                init_req,
  input  logic                dump_req,
  input  logic                run_active,
  output logic [base_log-1:0] base_id,
  output logic                init,
  output logic [63:0]         w_seed,
  output logic                read,
  input  logic [63:0]         r_seed,
  output logic [63:0]         dump_data,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic                busy,
  output logic                done
);

  localparam logic [base_log-1:0] LAST = base_log'(base_num - 1);

  seq_state_t          state;
  logic [63:0]         st;
  logic [63:0]         st_next;
  logic [63:0]         mixed;
  logic [base_log-1:0] cnt;

  // The mixer looks one step ahead so w_seed can be registered together with init.
  assign st_next = ((state == IDLE) ? master_seed : st) + SM_GAMMA;
  assign busy    = (state != IDLE);

  splitmix_mix u_mix (
    .z_in  (st_next),
    .z_out (mixed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      st         <= '0;
      cnt        <= '0;
      base_id    <= '0;
      init       <= 1'b0;
      w_seed     <= '0;
      read       <= 1'b0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!run_active) begin
            if (init_req) begin
              st      <= st_next;
              cnt     <= '0;
              base_id <= '0;
              init    <= 1'b1;
              w_seed  <= nonzero_seed(mixed);
              state   <= INIT;
            end else if (dump_req) begin
              cnt     <= '0;
              base_id <= '0;
              state   <= D_ADDR;
            end
          end
        end
        INIT: begin
          if (cnt == LAST) begin
            init  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt     <= cnt + 1'b1;
            base_id <= cnt + 1'b1;
            st      <= st_next;
            w_seed  <= nonzero_seed(mixed);
          end
        end
        D_ADDR: begin
          read  <= 1'b1;
          state <= D_READ;
        end
        D_READ: begin
          read  <= 1'b0;
          state <= D_CAP;
        end
        D_CAP: begin
          dump_data  <= r_seed;
          dump_valid <= 1'b1;
          state      <= D_OUT;
        end
        D_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (cnt == LAST) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cnt     <= cnt + 1'b1;
              base_id <= cnt + 1'b1;
              state   <= D_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_sequencer.sv
// Bench for seed_sequencer: seed store model, splitmix64 reference table,
// directed passes with randomized seeds and backpressure.
module tb_seed_sequencer;
  import replica_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [63:0]         master_seed;
  logic                init_req;
  logic                dump_req;
  logic                run_active;
  logic [base_log-1:0] base_id;
  logic                init;
  logic [63:0]         w_seed;
  logic                read;
  logic [63:0]         r_seed;
  logic [63:0]         dump_data;
  logic                dump_valid;
  logic                dump_ready;
  logic                busy;
  logic                done;

  logic [63:0] mem [base_num];
  logic [63:0] exp_tab [base_num];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seed_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .master_seed (master_seed),
    .init_req    (init_req),
    .dump_req    (dump_req),
    .run_active  (run_active),
    .base_id     (base_id),
    .init        (init),
    .w_seed      (w_seed),
    .read        (read),
    .r_seed      (r_seed),
    .dump_data   (dump_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .busy        (busy),
    .done        (done)
  );

  // Seed store: writes on the edge ending an init cycle, registered read path.
  always @(posedge clk) begin
    if (init) mem[base_id] <= w_seed;
    if (read) r_seed <= mem[base_id];
  end

  function automatic logic [63:0] ref_mix(input logic [63:0] x);
    logic [63:0] z;
    z = x;
    z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
    z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
    return z ^ (z >> 31);
  endfunction

  // Slot k holds the mix of master + (k+1)*gamma, zero replaced by one.
  task automatic build_model(input logic [63:0] seed);
    logic [63:0] v;
    for (int k = 0; k < base_num; k++) begin
      v = ref_mix(seed + 64'(k + 1) * 64'h9E3779B97F4A7C15);
      exp_tab[k] = (v == 64'd0) ? 64'd1 : v;
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after done clears.
  task automatic run_init(input logic [63:0] seed, input bit with_dump);
    build_model(seed);
    master_seed = seed;
    init_req    = 1'b1;
    dump_req    = with_dump;
    @(negedge clk);
    init_req    = 1'b0;
    dump_req    = 1'b0;
    master_seed = {$urandom, $urandom};
    for (int k = 0; k < base_num; k++) begin
      if (k > 0) @(negedge clk);
      check_output("init_strobe", 64'(init), 64'd1);
      check_output("init_base_id", 64'(base_id), 64'(k));
      check_output("init_w_seed", w_seed, exp_tab[k]);
      check_output("init_done_low", 64'(done), 64'd0);
    end
    @(negedge clk);
    check_output("init_end_strobe", 64'(init), 64'd0);
    check_output("init_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check_output("init_done_single", 64'(done), 64'd0);
    check_output("init_idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic run_dump(input bit random_ready);
    int cyc;
    int beats;
    int last_hs;
    int stall;
    bit pending;
    bit got_done;
    logic [63:0] held;
    dump_req   = 1'b1;
    dump_ready = 1'b0;
    @(negedge clk);
    dump_req = 1'b0;
    cyc      = 1;
    beats    = 0;
    last_hs  = 0;
    stall    = 0;
    pending  = 1'b0;
    got_done = 1'b0;
    held     = '0;
    while (!got_done && cyc < 3000) begin
      if (pending) begin
        check_output("hold_valid", 64'(dump_valid), 64'd1);
        check_output("hold_data", dump_data, held);
      end
      if (done) begin
        got_done = 1'b1;
        check_output("dump_beat_count", 64'(beats), 64'(base_num));
        check_output("dump_done_timing", 64'(cyc), 64'(last_hs + 1));
      end else begin
        if (!random_ready) dump_ready = 1'b1;
        else if (stall > 0) begin
          dump_ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 7) == 0) begin
          dump_ready = 1'b0;
          stall = 9;
        end else dump_ready = 1'($urandom_range(0, 1));
        if (dump_valid && dump_ready) begin
          if (beats < base_num) check_output("dump_beat", dump_data, exp_tab[beats]);
          else check_output("dump_extra_beat", 64'(beats), 64'(base_num - 1));
          if (!random_ready) begin
            if (beats == 0) check_output("dump_first_latency", 64'(cyc), 64'd4);
            else check_output("dump_beat_period", 64'(cyc - last_hs), 64'd4);
          end
          beats++;
          last_hs = cyc;
        end
        pending = dump_valid && !dump_ready;
        held    = dump_data;
      end
      @(negedge clk);
      cyc++;
    end
    check_output("dump_done_seen", 64'(got_done), 64'd1);
    dump_ready = 1'b0;
    check_output("dump_done_single", 64'(done), 64'd0);
    check_output("dump_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] seed;
    bit seen;
    reset       = 1'b0;
    master_seed = '0;
    init_req    = 1'b0;
    dump_req    = 1'b0;
    run_active  = 1'b0;
    dump_ready  = 1'b0;
    @(negedge clk);
    check_output("reset_ctrl", 64'({base_id, init, read, dump_valid, busy, done}), 64'd0);
    check_output("reset_w_seed", w_seed, 64'd0);
    check_output("reset_dump_data", dump_data, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] init from zero");
    run_init(64'd0, 1'b0);
    check_output("zero_slot0", mem[0], 64'hE220A8397B1DCDAF);
    check_output("zero_slot1", mem[1], 64'h6E789E6AA1B965F4);

    $display("[TB] zero substitution");
    run_init(64'h61C8864680B583EB, 1'b0);
    check_output("zero_sub_slot0", mem[0], 64'd1);

    $display("[TB] round trip");
    run_init(64'h0123456789ABCDEF, 1'b0);
    run_dump(1'b0);

    $display("[TB] backpressure");
    seed = {$urandom, $urandom};
    run_init(seed, 1'b0);
    run_dump(1'b1);

    $display("[TB] refusal while running");
    seen        = 1'b0;
    run_active  = 1'b1;
    init_req    = 1'b1;
    dump_req    = 1'b1;
    master_seed = {$urandom, $urandom};
    @(negedge clk);
    init_req = 1'b0;
    dump_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= busy | init | read;
      @(negedge clk);
    end
    run_active = 1'b0;
    check_output("refuse_activity", 64'(seen), 64'd0);

    $display("[TB] simultaneous requests");
    run_init({$urandom, $urandom}, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= busy | read | dump_valid;
      @(negedge clk);
    end
    check_output("no_dump_after_init", 64'(seen), 64'd0);

    $display("[TB] reset mid-pass");
    master_seed = {$urandom, $urandom};
    init_req    = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_at_slot3", 64'(base_id), 64'd3);
    reset = 1'b0;
    #1;
    check_output("rst_mid_ctrl", 64'({base_id, init, read, dump_valid, busy, done}), 64'd0);
    check_output("rst_mid_w_seed", w_seed, 64'd0);
    check_output("rst_mid_dump_data", dump_data, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_init({$urandom, $urandom}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
